bp_me_lce_latency_monitor: RTL and testbench



---
 rtl/bp_me_lce_latency_monitor.sv | 191 +++++++++++++++++++
 tb/tb_bp_me_lce_latency_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_lce_latency_monitor.sv
// Multi-channel LCE request-latency monitor.
// Each channel timestamps accepted requests into a small in-order queue,
// retires the oldest entry on a completion pulse and keeps count, min, max,
// saturating sum and last latency. Stuck requests and queue misuse raise
// sticky flags. Statistics are read back through a combinational mux.
//
// Ports:
//   clk_i, reset_i       clock, asynchronous active-low reset
//   req_v_i              per-channel request valid
//   req_ready_and_i      per-channel request ready (push on v & ready)
//   complete_i           per-channel completion pulse (pops oldest entry)
//   clear_i              synchronous clear of statistics and sticky flags
//   stat_ch_i            channel selected for readout
//   stat_sel_i           0 count, 1 min, 2 max, 3 sum, 4 occupancy,
//                        5 last, 6 age of oldest, 7 zero
//   stat_o               selected statistic, zero-extended
//   timeout_o            sticky: oldest request reached timeout_p cycles
//   overflow_o           sticky: push attempted while queue full
//   underflow_o          sticky: completion while queue empty
//
// Optional build macro BP_ME_LATMON_TRACE_EN adds simulation-only per-channel
// trace output; functional behaviour is unchanged.
module bp_me_lce_latency_monitor #(
  parameter int unsigned num_ch_p          = 2,
  parameter int unsigned max_outstanding_p = 4,
  parameter int unsigned cnt_width_p       = 32,
  parameter int unsigned sum_width_p       = 48,
  parameter int unsigned timeout_p         = 1024,
  localparam int unsigned ch_width_lp      = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_ch_p-1:0]    req_v_i,
  input  logic [num_ch_p-1:0]    req_ready_and_i,
  input  logic [num_ch_p-1:0]    complete_i,
  input  logic                   clear_i,
  input  logic [ch_width_lp-1:0] stat_ch_i,
  input  logic [2:0]             stat_sel_i,
  output logic [sum_width_p-1:0] stat_o,
  output logic [num_ch_p-1:0]    timeout_o,
  output logic [num_ch_p-1:0]    overflow_o,
  output logic [num_ch_p-1:0]    underflow_o
);

  localparam int unsigned ptr_width_lp     = $clog2(max_outstanding_p);
  localparam int unsigned occ_width_lp     = ptr_width_lp + 1;
  localparam int unsigned sum_ext_width_lp = sum_width_p + 1;

  logic [cnt_width_p-1:0]  now_r;
  logic [cnt_width_p-1:0]  ts_mem [num_ch_p][max_outstanding_p];
  logic [ptr_width_lp-1:0] head_r [num_ch_p];
  logic [ptr_width_lp-1:0] tail_r [num_ch_p];
  logic [occ_width_lp-1:0] occ_r  [num_ch_p];
  logic [occ_width_lp-1:0] occ_n  [num_ch_p];

  logic [cnt_width_p-1:0]  cnt_r  [num_ch_p], cnt_n  [num_ch_p], cnt_b [num_ch_p];
  logic [cnt_width_p-1:0]  min_r  [num_ch_p], min_n  [num_ch_p], min_b [num_ch_p];
  logic [cnt_width_p-1:0]  max_r  [num_ch_p], max_n  [num_ch_p], max_b [num_ch_p];
  logic [cnt_width_p-1:0]  last_r [num_ch_p], last_n [num_ch_p];
  logic [sum_width_p-1:0]  sum_r  [num_ch_p], sum_n  [num_ch_p], sum_b [num_ch_p];
  logic [sum_ext_width_lp-1:0] sum_ext [num_ch_p];
  logic [cnt_width_p-1:0]  age    [num_ch_p];

  logic [num_ch_p-1:0] empty, full, push_hs, push, pop;
  logic [num_ch_p-1:0] timeout_n, overflow_n, underflow_n;

  // Queue control and statistics next-state; a clear in the same cycle
  // replaces the stored stats with reset values before any update.
  always_comb begin
    empty       = '0;
    full        = '0;
    push_hs     = '0;
    push        = '0;
    pop         = '0;
    timeout_n   = '0;
    overflow_n  = '0;
    underflow_n = '0;
    for (int c = 0; c < num_ch_p; c++) begin
      age[c]     = now_r - ts_mem[c][head_r[c]];
      empty[c]   = (occ_r[c] == '0);
      full[c]    = (occ_r[c] == occ_width_lp'(max_outstanding_p));
      pop[c]     = complete_i[c] & ~empty[c];
      push_hs[c] = req_v_i[c] & req_ready_and_i[c];
      push[c]    = push_hs[c] & (~full[c] | pop[c]);

      case ({push[c], pop[c]})
        2'b10:   occ_n[c] = occ_r[c] + 1'b1;
        2'b01:   occ_n[c] = occ_r[c] - 1'b1;
        default: occ_n[c] = occ_r[c];
      endcase

      cnt_b[c] = clear_i ? '0 : cnt_r[c];
      min_b[c] = clear_i ? '1 : min_r[c];
      max_b[c] = clear_i ? '0 : max_r[c];
      sum_b[c] = clear_i ? '0 : sum_r[c];

      cnt_n[c]   = cnt_b[c];
      min_n[c]   = min_b[c];
      max_n[c]   = max_b[c];
      sum_n[c]   = sum_b[c];
      last_n[c]  = clear_i ? '0 : last_r[c];
      sum_ext[c] = {1'b0, sum_b[c]} + sum_ext_width_lp'(age[c]);
      if (pop[c]) begin
        cnt_n[c]  = (cnt_b[c] == '1) ? cnt_b[c] : cnt_b[c] + 1'b1;
        sum_n[c]  = sum_ext[c][sum_width_p] ? '1 : sum_ext[c][sum_width_p-1:0];
        min_n[c]  = (age[c] < min_b[c]) ? age[c] : min_b[c];
        max_n[c]  = (age[c] > max_b[c]) ? age[c] : max_b[c];
        last_n[c] = age[c];
      end

      timeout_n[c]   = (~clear_i & timeout_o[c])
                     | (~empty[c] & (age[c] >= cnt_width_p'(timeout_p)));
      overflow_n[c]  = (~clear_i & overflow_o[c]) | (push_hs[c] & full[c] & ~pop[c]);
      underflow_n[c] = (~clear_i & underflow_o[c]) | (complete_i[c] & empty[c]);
    end
  end

  // State registers: timestamp counter, queues, statistics and flags.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      now_r       <= '0;
      timeout_o   <= '0;
      overflow_o  <= '0;
      underflow_o <= '0;
      for (int c = 0; c < num_ch_p; c++) begin
        head_r[c] <= '0;
        tail_r[c] <= '0;
        occ_r[c]  <= '0;
        cnt_r[c]  <= '0;
        min_r[c]  <= '1;
        max_r[c]  <= '0;
        sum_r[c]  <= '0;
        last_r[c] <= '0;
        for (int i = 0; i < max_outstanding_p; i++) ts_mem[c][i] <= '0;
      end
    end else begin
      now_r       <= now_r + 1'b1;
      timeout_o   <= timeout_n;
      overflow_o  <= overflow_n;
      underflow_o <= underflow_n;
      for (int c = 0; c < num_ch_p; c++) begin
        if (push[c]) begin
          ts_mem[c][tail_r[c]] <= now_r;
          tail_r[c]            <= tail_r[c] + 1'b1;
        end
        if (pop[c]) head_r[c] <= head_r[c] + 1'b1;
        occ_r[c]  <= occ_n[c];
        cnt_r[c]  <= cnt_n[c];
        min_r[c]  <= min_n[c];
        max_r[c]  <= max_n[c];
        sum_r[c]  <= sum_n[c];
        last_r[c] <= last_n[c];
      end
    end
  end

  // Readout mux; out-of-range channels read zero.
  always_comb begin
    stat_o = '0;
    if (32'(stat_ch_i) < num_ch_p) begin
      case (stat_sel_i)
        3'd0: stat_o = sum_width_p'(cnt_r[stat_ch_i]);
        3'd1: stat_o = sum_width_p'(min_r[stat_ch_i]);
        3'd2: stat_o = sum_width_p'(max_r[stat_ch_i]);
        3'd3: stat_o = sum_r[stat_ch_i];
        3'd4: stat_o = sum_width_p'(occ_r[stat_ch_i]);
        3'd5: stat_o = sum_width_p'(last_r[stat_ch_i]);
        3'd6: stat_o = empty[stat_ch_i] ? '0 : sum_width_p'(age[stat_ch_i]);
        default: stat_o = '0;
      endcase
    end
  end

`ifdef BP_ME_LATMON_TRACE_EN
  // Simulation-only event trace, tagged per channel.
  always @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < num_ch_p; c++) begin
        if (pop[c])
          $display("[%0t] CH%0d lat=%0d occ=%0d", $time, c, age[c], occ_n[c]);
        if (timeout_n[c] & ~timeout_o[c])     $display("[%0t] CH%0d TIMEOUT", $time, c);
        if (overflow_n[c] & ~overflow_o[c])   $display("[%0t] CH%0d OVERFLOW", $time, c);
        if (underflow_n[c] & ~underflow_o[c]) $display("[%0t] CH%0d UNDERFLOW", $time, c);
      end
    end
  end
`else
  // Trace disabled: no trace output in this build.
`endif

endmodule

// File: tb/tb_bp_me_lce_latency_monitor.sv
// Randomized and directed bench for bp_me_lce_latency_monitor against a
// queue-based reference model of the latency statistics.
module tb_bp_me_lce_latency_monitor;

  localparam int NCH = 3;
  localparam int DEPTH = 4;
  localparam int CW = 8;
  localparam int SW = 12;
  localparam int TO = 16;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [NCH-1:0] req_v, req_rdy, cmp;
  logic           clear;
  logic [1:0]     stat_ch;
  logic [2:0]     stat_sel;
  logic [SW-1:0]  stat;
  logic [NCH-1:0] tout, ovf, und;

  bp_me_lce_latency_monitor #(
    .num_ch_p(NCH), .max_outstanding_p(DEPTH), .cnt_width_p(CW),
    .sum_width_p(SW), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_n),
    .req_v_i(req_v), .req_ready_and_i(req_rdy), .complete_i(cmp),
    .clear_i(clear), .stat_ch_i(stat_ch), .stat_sel_i(stat_sel),
    .stat_o(stat), .timeout_o(tout), .overflow_o(ovf), .underflow_o(und)
  );

  // Reference model
  int mq [NCH][$];
  int m_now;
  int m_cnt [NCH], m_sum [NCH], m_min [NCH], m_max [NCH], m_last [NCH];
  bit [NCH-1:0] m_tout, m_ovf, m_und;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_stat(int ch, int sel);
    if (ch >= NCH) return 0;
    case (sel)
      0: return m_cnt[ch];
      1: return m_min[ch];
      2: return m_max[ch];
      3: return m_sum[ch];
      4: return mq[ch].size();
      5: return m_last[ch];
      6: return (mq[ch].size() > 0) ? ((m_now - mq[ch][0]) & CMAX) : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_now = 0;
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_cnt[c] = 0; m_sum[c] = 0; m_min[c] = CMAX; m_max[c] = 0; m_last[c] = 0;
    end
    m_tout = '0; m_ovf = '0; m_und = '0;
  endtask

  // One clock of the model using the inputs currently applied.
  task automatic model_clock();
    int lat;
    for (int c = 0; c < NCH; c++) begin
      if (clear) begin
        m_cnt[c] = 0; m_sum[c] = 0; m_min[c] = CMAX; m_max[c] = 0; m_last[c] = 0;
        m_tout[c] = 1'b0; m_ovf[c] = 1'b0; m_und[c] = 1'b0;
      end
      if (mq[c].size() > 0 && ((m_now - mq[c][0]) & CMAX) >= TO) m_tout[c] = 1'b1;
      if (cmp[c]) begin
        if (mq[c].size() > 0) begin
          lat = (m_now - mq[c].pop_front()) & CMAX;
          m_cnt[c] = (m_cnt[c] + 1 > CMAX) ? CMAX : m_cnt[c] + 1;
          m_sum[c] = (m_sum[c] + lat > SMAX) ? SMAX : m_sum[c] + lat;
          if (lat < m_min[c]) m_min[c] = lat;
          if (lat > m_max[c]) m_max[c] = lat;
          m_last[c] = lat;
        end else begin
          m_und[c] = 1'b1;
        end
      end
      if (req_v[c] && req_rdy[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(m_now);
        else m_ovf[c] = 1'b1;
      end
    end
    m_now = (m_now + 1) & CMAX;
  endtask

  // Apply one cycle of stimulus, compare all outputs, optionally compare stat_o
  // against a fixed expected value, then advance the model with the clock.
  task automatic cyc_p(input bit [NCH-1:0] v, input bit [NCH-1:0] r, input bit [NCH-1:0] c,
                       input bit clr, input int ch, input int sel,
                       input bit pe, input int pexp, input string ptag);
    @(negedge clk);
    req_v = v; req_rdy = r; cmp = c; clear = clr;
    stat_ch = 2'(ch); stat_sel = 3'(sel);
    #1;
    check($sformatf("stat ch%0d sel%0d", ch, sel), 32'(stat), 32'(model_stat(ch, sel)));
    check("timeout", 32'(tout), 32'(m_tout));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("underflow", 32'(und), 32'(m_und));
    if (pe) check(ptag, 32'(stat), 32'(pexp));
    @(posedge clk);
    model_clock();
  endtask

  task automatic cyc(input bit [NCH-1:0] v, input bit [NCH-1:0] c, input bit clr,
                     input int ch, input int sel);
    cyc_p(v, '1, c, clr, ch, sel, 1'b0, 0, "");
  endtask

  task automatic probe(input int ch, input int sel, input int exp, input string tag);
    cyc_p('0, '1, '0, 1'b0, ch, sel, 1'b1, exp, tag);
  endtask

  initial begin
    int p_push, p_cmp, p_rdy;
    bit [NCH-1:0] v, r, c;
    reset_n = 1'b0; req_v = '0; req_rdy = '0; cmp = '0; clear = 1'b0;
    stat_ch = '0; stat_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    probe(0, 0, 0, "reset count");
    probe(0, 1, CMAX, "reset min");
    probe(1, 6, 0, "reset age");

    // Single request on ch0, latency 7
    cyc(3'b001, 3'b000, 1'b0, 0, 6);
    repeat (6) cyc(3'b000, 3'b000, 1'b0, 0, 6);
    cyc(3'b000, 3'b001, 1'b0, 0, 6);
    probe(0, 5, 7, "single last");
    probe(0, 0, 1, "single count");
    probe(0, 3, 7, "single sum");
    probe(0, 4, 0, "single occ");

    // Four back-to-back pushes on ch1, fifth overflows, latency 10 each
    repeat (4) cyc(3'b010, 3'b000, 1'b0, 1, 4);
    cyc(3'b010, 3'b000, 1'b0, 1, 4);
    probe(1, 4, 4, "full occ");
    repeat (4) cyc(3'b000, 3'b000, 1'b0, 1, 6);
    repeat (4) cyc(3'b000, 3'b010, 1'b0, 1, 5);
    probe(1, 3, 40, "b2b sum");
    probe(1, 2, 10, "b2b max");

    // Underflow on ch0 then clear
    cyc(3'b000, 3'b001, 1'b0, 0, 0);
    probe(0, 0, 1, "underflow count");
    cyc(3'b000, 3'b000, 1'b1, 0, 1);
    probe(0, 1, CMAX, "clear min");

    // Timeout on ch2, sticky past completion until clear
    cyc(3'b100, 3'b000, 1'b0, 2, 6);
    repeat (20) cyc(3'b000, 3'b000, 1'b0, 2, 6);
    cyc(3'b000, 3'b100, 1'b0, 2, 5);
    repeat (2) cyc(3'b000, 3'b000, 1'b0, 2, 0);
    cyc(3'b000, 3'b000, 1'b1, 2, 0);
    cyc(3'b000, 3'b000, 1'b0, 2, 0);

    // Same-cycle push+pop on ch0 at occupancy 2
    repeat (2) cyc(3'b001, 3'b000, 1'b0, 0, 4);
    cyc(3'b001, 3'b001, 1'b0, 0, 4);
    probe(0, 4, 2, "pushpop occ");

    // Randomized traffic (counter wraps many times)
    for (int seg = 0; seg < 10; seg++) begin
      p_push = $urandom_range(10, 90);
      p_cmp  = $urandom_range(5, 80);
      p_rdy  = $urandom_range(40, 100);
      for (int n = 0; n < 250; n++) begin
        for (int k = 0; k < NCH; k++) begin
          v[k] = ($urandom_range(0, 99) < p_push);
          r[k] = ($urandom_range(0, 99) < p_rdy);
          c[k] = ($urandom_range(0, 99) < p_cmp);
        end
        cyc_p(v, r, c, ($urandom_range(0, 199) == 0), $urandom_range(0, 3),
              $urandom_range(0, 7), 1'b0, 0, "");
      end
    end

    // Asynchronous reset mid-cycle takes effect without a clock edge
    cyc(3'b011, 3'b000, 1'b0, 1, 0);
    @(negedge clk);
    req_v = '0; cmp = '0; clear = 1'b0; stat_ch = 2'd1; stat_sel = 3'd0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async count", 32'(stat), 32'(0));
    check("async flags", 32'({tout, ovf, und}), 32'(0));
    stat_sel = 3'd1;
    #1;
    check("async min", 32'(stat), 32'(CMAX));
    stat_sel = 3'd4;
    #1;
    check("async occ", 32'(stat), 32'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    probe(1, 0, 0, "post reset count");
    repeat (5) cyc(3'b111, 3'b000, 1'b0, 2, 4);
    repeat (3) cyc(3'b000, 3'b111, 1'b0, 2, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
